// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage with private HI/LO registers.
// Optional divide datapath: define MULDIV_DIV_EN to include DIV/DIVU support.
module ex_muldiv #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        cancel_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        divzero_o,
  output logic [1:0]  state_o
);

  // Handshake: start_i is a one-cycle request that is accepted only in IDLE
  // (busy_o low); done_o is the matching one-cycle completion pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_nx;
  logic        sign1_q, sign2_q;
  logic [31:0] operand_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q, acc_nx;
  logic [31:0] hi_q, lo_q;
  logic        done_q;
  logic        accept;
  logic        neg1, neg2;
  logic [31:0] in_mag1, in_mag2;
  logic [31:0] res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic        is_div_q;
  logic [31:0] data1_q;
  logic        divzero_q;
  assign accept = start_i;
`else
  assign accept = start_i & ~op_i[1];
`endif

  assign neg1    = ~op_i[0] & data1_i[31];
  assign neg2    = ~op_i[0] & data2_i[31];
  assign in_mag1 = neg1 ? 32'(-data1_i) : data1_i;
  assign in_mag2 = neg2 ? 32'(-data2_i) : data2_i;

  // acc = {partial product, remaining multiplier bits}
  function automatic logic [63:0] mul_step(input logic [63:0] a, input logic [31:0] m);
    logic [32:0] sum;
    sum = {1'b0, a[63:32]} + {1'b0, (a[0] ? m : 32'd0)};
    return {sum, a[31:1]};
  endfunction

`ifdef MULDIV_DIV_EN
  // acc = {partial remainder, dividend bits shifting into quotient}
  function automatic logic [63:0] div_step(input logic [63:0] a, input logic [31:0] d);
    logic [32:0] trial;
    trial = a[63:31];
    if (trial >= {1'b0, d}) begin
      trial = trial - {1'b0, d};
      return {trial[31:0], a[30:0], 1'b1};
    end
    return {trial[31:0], a[30:0], 1'b0};
  endfunction
`endif

  always_comb begin
    acc_nx = acc_q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
`ifdef MULDIV_DIV_EN
      if (is_div_q) acc_nx = div_step(acc_nx, operand_q);
      else          acc_nx = mul_step(acc_nx, operand_q);
`else
      acc_nx = mul_step(acc_nx, operand_q);
`endif
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        if (cancel_i)                                     state_nx = IDLE;
        else if (cnt_q + 6'(STEPS_PER_CYCLE) == 6'd32)    state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sign fix-up; sign flags are only ever set for the signed ops.
  always_comb begin
    res_hi = acc_q[63:32];
    res_lo = acc_q[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div_q) begin
      if (operand_q == 32'd0) begin
        res_hi = data1_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        if (sign1_q ^ sign2_q) res_lo = 32'(-acc_q[31:0]);
        if (sign1_q)           res_hi = 32'(-acc_q[63:32]);
      end
    end else if (sign1_q ^ sign2_q) begin
      {res_hi, res_lo} = -acc_q;
    end
`else
    if (sign1_q ^ sign2_q) {res_hi, res_lo} = -acc_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      operand_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      data1_q   <= '0;
      divzero_q <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      divzero_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (accept) begin
            sign1_q   <= neg1;
            sign2_q   <= neg2;
            cnt_q     <= '0;
            // Divide iterates on the dividend against the divisor; multiply the reverse.
            operand_q <= op_i[1] ? in_mag2 : in_mag1;
            acc_q     <= {32'd0, (op_i[1] ? in_mag1 : in_mag2)};
`ifdef MULDIV_DIV_EN
            is_div_q  <= op_i[1];
            data1_q   <= data1_i;
`endif
          end
        end
        RUN: begin
          if (!cancel_i) begin
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 6'(STEPS_PER_CYCLE);
          end
        end
        FIX: begin
          if (!cancel_i) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
            divzero_q <= is_div_q & (operand_q == 32'd0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state != IDLE);
  assign done_o  = done_q;
  assign state_o = state;
`ifdef MULDIV_DIV_EN
  assign divzero_o = divzero_q;
`else
  assign divzero_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: arithmetic reference model, timing, cancel, MTHI/MTLO and reset cases.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data1, data2;
  logic        cancel, hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, divzero;
  logic [1:0]  state;

  logic        start4;
  logic [1:0]  op4;
  logic [31:0] d14, d24;
  logic        zero4 = 1'b0;
  logic [31:0] zw4 = 32'd0;
  logic [31:0] hi4, lo4;
  logic        busy4, done4, divzero4;
  logic [1:0]  state4;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  ex_muldiv #(.STEPS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .op_i(op),
    .data1_i(data1), .data2_i(data2), .cancel_i(cancel),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done),
    .divzero_o(divzero), .state_o(state)
  );

  ex_muldiv #(.STEPS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start4), .op_i(op4),
    .data1_i(d14), .data2_i(d24), .cancel_i(zero4),
    .hi_we_i(zero4), .lo_we_i(zero4), .wdata_i(zw4),
    .hi_o(hi4), .lo_o(lo4), .busy_o(busy4), .done_o(done4),
    .divzero_o(divzero4), .state_o(state4)
  );

  // Returns {divzero, hi, lo} from plain arithmetic on the operation definition.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, 64'(p)}; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return {1'b0, up}; end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; data1 = a; data2 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n = edges after the start edge until done_o is seen; bn = samples with busy_o high.
  task automatic wait_done(output int n, output int bn);
    n = 0;
    bn = busy ? 1 : 0;
    while (!done && n < 100) begin
      tick();
      n++;
      if (busy) bn++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; op = 0; data1 = 0; data2 = 0; cancel = 0;
    hi_we = 0; lo_we = 0; wdata = 0; start4 = 0; op4 = 0; d14 = 0; d24 = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({hi, lo} !== 64'd0) begin
      failures++; $display("FAIL reset_hilo: got %h_%h expected 0_0", hi, lo);
    end
    checks++;
    if ({busy, done, divzero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {busy, done, divzero});
    end
    checks++;
    if ({busy4, done4, divzero4, hi4, lo4} !== 67'd0) begin
      failures++; $display("FAIL reset_dut4: got %b %h %h expected zeros", {busy4, done4, divzero4}, hi4, lo4);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  ops[30];
    logic [31:0] as[30], bs[30];
    logic [64:0] exp;
    logic [31:0] hb, lb;
    logic        accepted;
    int n, bn, bad;
    ops[0] = 2'b00; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd2;
    ops[1] = 2'b01; as[1] = 32'hFFFF_FFFF; bs[1] = 32'd2;
    ops[2] = 2'b10; as[2] = 32'hFFFF_FFF9; bs[2] = 32'd2;
    ops[3] = 2'b11; as[3] = 32'd100;       bs[3] = 32'd7;
    ops[4] = 2'b11; as[4] = 32'd7;         bs[4] = 32'd0;
    ops[5] = 2'b10; as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF;
    for (int i = 6; i < 30; i++) begin
      ops[i] = 2'($urandom_range(0, 3));
      as[i] = $urandom();
      bs[i] = $urandom();
      case ($urandom_range(0, 7))
        0: bs[i] = 32'd0;
        1: begin as[i] = 32'h8000_0000; bs[i] = 32'hFFFF_FFFF; end
        2: bs[i] = 32'($urandom_range(1, 20));
        default: ;
      endcase
    end
    for (int i = 0; i < 30; i++) begin
`ifdef MULDIV_DIV_EN
      accepted = 1'b1;
`else
      accepted = ~ops[i][1];
`endif
      hb = hi; lb = lo;
      if (accepted) exp_q.push_back(ref_model(ops[i], as[i], bs[i]));
      start_op(ops[i], as[i], bs[i]);
      if (accepted) begin
        wait_done(n, bn);
        exp = exp_q.pop_front();
        checks++;
        if (n !== 33) begin
          failures++; $display("FAIL latency[%0d]: got %0d edges expected 33", i, n);
        end
        checks++;
        if (bn !== 33) begin
          failures++; $display("FAIL busy_len[%0d]: got %0d cycles expected 33", i, bn);
        end
        checks++;
        if ({divzero, hi, lo} !== exp) begin
          failures++;
          $display("FAIL result[%0d] op=%0d a=%h b=%h: got dz=%b hi=%h lo=%h expected dz=%b hi=%h lo=%h",
                   i, ops[i], as[i], bs[i], divzero, hi, lo, exp[64], exp[63:32], exp[31:0]);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
          failures++; $display("FAIL done_pulse[%0d]: got done=%b expected 0", i, done);
        end
      end else begin
        bad = (busy || done) ? 1 : 0;
        repeat (40) begin
          tick();
          if (busy || done) bad++;
        end
        checks++;
        if (bad !== 0) begin
          failures++; $display("FAIL div_disabled[%0d]: got %0d busy/done samples expected 0", i, bad);
        end
        checks++;
        if ({hi, lo} !== {hb, lb}) begin
          failures++; $display("FAIL div_disabled_hilo[%0d]: got %h_%h expected %h_%h", i, hi, lo, hb, lb);
        end
      end
    end
  endtask

  task automatic test_cancel();
    int bad;
    hi_we = 1; wdata = 32'hAAAA_5555; tick(); hi_we = 0;
    lo_we = 1; wdata = 32'h5555_AAAA; tick(); lo_we = 0;
    start_op(2'b00, 32'd3, 32'd5);
    repeat (10) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle: got busy=%b expected 0", busy);
    end
    bad = 0;
    repeat (40) begin
      tick();
      if (done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL cancel_no_done: got %0d done pulses expected 0", bad);
    end
    checks++;
    if ({hi, lo} !== 64'hAAAA_5555_5555_AAAA) begin
      failures++; $display("FAIL cancel_hilo: got %h_%h expected aaaa5555_5555aaaa", hi, lo);
    end
    lo_we = 1; wdata = 32'h0000_1234; tick(); lo_we = 0;
    checks++;
    if ({hi, lo} !== 64'hAAAA_5555_0000_1234) begin
      failures++; $display("FAIL mtlo_after_cancel: got %h_%h expected aaaa5555_00001234", hi, lo);
    end
  endtask

  task automatic test_start_mid_run();
    logic [31:0] a, b, lb;
    logic [64:0] exp;
    int n, bn;
    a = $urandom(); b = $urandom();
    exp_q.push_back(ref_model(2'b01, a, b));
    start_op(2'b01, a, b);
    repeat (10) tick();
    lb = lo;
    op = 2'b00; data1 = $urandom(); data2 = $urandom(); start = 1'b1;
    lo_we = 1'b1; wdata = ~lb;
    tick();
    start = 1'b0; lo_we = 1'b0;
    checks++;
    if (lo !== lb) begin
      failures++; $display("FAIL mtlo_while_busy: got lo=%h expected %h", lo, lb);
    end
    wait_done(n, bn);
    exp = exp_q.pop_front();
    checks++;
    if (n !== 22) begin
      failures++; $display("FAIL midrun_latency: got %0d edges expected 22", n);
    end
    checks++;
    if ({divzero, hi, lo} !== exp) begin
      failures++; $display("FAIL midrun_result: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL midrun_start_ignored: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [64:0] exp;
    int n, bn;
    a = $urandom(); b = $urandom();
    exp_q.push_back(ref_model(2'b00, a, b));
    start_op(2'b00, a, b);
    wait_done(n, bn);
    exp = exp_q.pop_front();
    checks++;
    if ({divzero, hi, lo} !== exp) begin
      failures++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hi, lo, exp[63:32], exp[31:0]);
    end
    a = $urandom(); b = $urandom();
    exp_q.push_back(ref_model(2'b01, a, b));
    start_op(2'b01, a, b);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL b2b_accept: got busy=%b expected 1", busy);
    end
    wait_done(n, bn);
    exp = exp_q.pop_front();
    checks++;
    if (n !== 33 || {divzero, hi, lo} !== exp) begin
      failures++;
      $display("FAIL b2b_second: got n=%0d %h_%h expected n=33 %h_%h", n, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_mthi_with_start();
    int n, bn;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    start_op(2'b01, 32'd6, 32'd7);
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL mthi_with_start: got hi=%h expected deadbeef", hi);
    end
    wait_done(n, bn);
    checks++;
    if ({hi, lo} !== 64'd42) begin
      failures++; $display("FAIL mthi_overwritten: got %h_%h expected 0_0000002a", hi, lo);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    hi_we = 1; lo_we = 1; wdata = 32'h1111_1111; tick(); hi_we = 0; lo_we = 0;
    start_op(2'b00, $urandom(), $urandom());
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo, busy, done, divzero} !== 67'd0) begin
      failures++; $display("FAIL reset_midrun: got hi=%h lo=%h flags=%b expected zeros", hi, lo, {busy, done, divzero});
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (busy || done) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL reset_discard: got %0d busy/done samples expected 0", bad);
    end
  endtask

  task automatic test_steps4();
    logic [64:0] exp;
    int n;
    for (int i = 0; i < 5; i++) begin
      op4 = 2'($urandom_range(0, 1));
      d14 = (i == 0) ? 32'hFFFF_FFFF : $urandom();
      d24 = (i == 0) ? 32'hFFFF_FFFF : $urandom();
      if (i == 0) op4 = 2'b01;
      exp = ref_model(op4, d14, d24);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 9) begin
        failures++; $display("FAIL s4_latency[%0d]: got %0d edges expected 9", i, n);
      end
      checks++;
      if ({hi4, lo4} !== exp[63:0]) begin
        failures++; $display("FAIL s4_result[%0d]: got %h_%h expected %h_%h", i, hi4, lo4, exp[63:32], exp[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_cancel();
    test_start_mid_run();
    test_back_to_back();
    test_mthi_with_start();
    test_reset_mid_run();
    test_steps4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. It consumes the register operands (data1 = rs, data2 = rt) latched by ID/EX and executes MULT/MULTU/DIV/DIVU over multiple cycles. Results go into its private HI/LO registers. It raises busy so the hazard unit can stall younger HI/LO consumers.

## Interface
- STEPS_PER_CYCLE, 1: radix steps per RUN cycle. Legal values: 1, 2, 4.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  launch an operation; sampled only in IDLE.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- data1_i  input  32  rs operand (multiplicand / dividend).
- data2_i  input  32  rt operand (multiplier / divisor).
- cancel_i  input  1  abort in-flight operation (pipeline flush).
- hi_we_i  input  1  MTHI write strobe.
- lo_we_i  input  1  MTLO write strobe.
- wdata_i  input  32  MTHI/MTLO data.
- hi_o  output  32  HI register.
- lo_o  output  32  LO register.
- busy_o  output  1  high while state != IDLE (decoded from state).
- done_o  output  1  registered one-cycle pulse when HI/LO take a result.
- divzero_o  output  1  registered; high together with done_o when a divide had data2 = 0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start_i = 1 (legal op):
  - Latch op, the signs of both operands, and their unsigned magnitudes. Signed ops take the absolute value; 0x80000000 stays 0x80000000.
  - Clear the step counter and go to RUN.
- RUN:
  - Each edge performs STEPS_PER_CYCLE iterations of shift-add multiply or restoring divide on the 64-bit accumulator.
  - After 32 iterations, go to FIX.
- FIX, one edge:
  - Apply sign correction and write HI/LO.
  - Pulse done_o and return to IDLE.
- Result mapping:
  - Multiply: {HI,LO} = 64-bit product. Signed product is negated if sign1 ^ sign2.
  - Divide: LO = quotient, negated if sign1 ^ sign2. HI = remainder, takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap).
- Divide by zero (data2 = 0):
  - Full latency is kept.
  - Result is HI = original data1_i, LO = 0xFFFFFFFF, divzero_o = 1.
- cancel_i in RUN or FIX: return to IDLE next edge. HI/LO are unchanged and there is no done_o. cancel_i in IDLE has no effect.
- start_i while busy_o = 1 is ignored.
- MTHI/MTLO:
  - Honoured only in IDLE; ignored while busy.
  - start_i and a write in the same IDLE cycle are both applied. The write lands now; the result overwrites HI/LO later.
- Reset: state IDLE; hi_o, lo_o = 0; done_o, divzero_o, busy_o = 0; counter and accumulator cleared. Reset mid-operation discards the operation.

## Timing
- Edge E0 samples start_i. busy_o is high from after E0.
- RUN occupies edges E1 .. E(32/STEPS_PER_CYCLE).
- FIX at edge E(32/S+1) writes HI/LO, sets done_o, and drops busy_o.
- With S = 1, done_o is high in the cycle following E33: 33 edges after the start edge.
- done_o is high for exactly one cycle.
- A new start_i in that same done_o cycle is accepted, giving back-to-back operations.
- hi_o/lo_o change only at a FIX edge or an MTHI/MTLO edge.

## Configuration
- MULDIV_DIV_EN defined: the full unit as described.
- MULDIV_DIV_EN undefined:
  - Divide datapath is compiled out.
  - start_i with op_i[1] = 1 is ignored: state stays IDLE, no busy_o, no done_o.
  - divzero_o is tied 0.
  - MULT/MULTU timing is unchanged.

## Test plan
- MULT, data1 = 0xFFFFFFFF, data2 = 0x00000002, S = 1 -> after 33 edges done_o = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. busy_o high for 33 cycles.
- MULTU, same operands -> HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV, data1 = 0xFFFFFFF9 (-7), data2 = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, 100 / 7 -> LO = 14, HI = 2.
- DIVU 7 / 0 -> done_o and divzero_o high together, HI = 7, LO = 0xFFFFFFFF. Repeat with the macro undefined -> no busy_o, no done_o.
- MULT 3 x 5 with cancel_i pulsed at E10 -> IDLE at E11, no done_o, HI/LO keep their prior values. A following MTLO 0x1234 in IDLE -> LO = 0x1234.
- Edge and reset cases:
  - start_i asserted mid-RUN -> ignored.
  - rst_i low mid-RUN -> outputs zero immediately.
  - S = 4, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o after 9 edges, HI = 0xFFFFFFFE, LO = 0x00000001.
